// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one AXI-lite-style memory port between two requesters:
//   m0 (sort controller read/write path) and m1 (host preload/readback).
//   One transaction is in flight at a time. Grants are round-robin when both
//   requesters ask in the same cycle. Reads run AR then R; writes run AW and W
//   together, then B. The owner sees a one-cycle ack when its fields are
//   latched and a one-cycle done when read data / response are valid.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   m{0,1}_req/_we/_addr/_wdata    request side, held stable until ack
//   m{0,1}_ack/_done               one-cycle pulses to the requester
//   m{0,1}_rdata/_resp             result registers, held until next completion
//   ar_*, r_*                      read address / read data channels
//   aw_*, w_*, b_*                 write address / write data / response channels
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_WDTH-1:0] m0_addr,
   input  logic [DATA_WDTH-1:0] m0_wdata,
   output logic                 m0_ack,
   output logic                 m0_done,
   output logic [DATA_WDTH-1:0] m0_rdata,
   output logic [RESP_WDTH-1:0] m0_resp,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_WDTH-1:0] m1_addr,
   input  logic [DATA_WDTH-1:0] m1_wdata,
   output logic                 m1_ack,
   output logic                 m1_done,
   output logic [DATA_WDTH-1:0] m1_rdata,
   output logic [RESP_WDTH-1:0] m1_resp,
   output logic                 ar_valid,
   input  logic                 ar_ready,
   output logic [ADDR_WDTH-1:0] ar_addr,
   input  logic                 r_valid,
   output logic                 r_ready,
   input  logic [DATA_WDTH-1:0] r_data,
   input  logic [RESP_WDTH-1:0] r_resp,
   output logic                 aw_valid,
   input  logic                 aw_ready,
   output logic [ADDR_WDTH-1:0] aw_addr,
   output logic                 w_valid,
   input  logic                 w_ready,
   output logic [DATA_WDTH-1:0] w_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [RESP_WDTH-1:0] b_resp
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_A  = 3'd1;
   localparam logic [2:0] S_RD_D  = 3'd2;
   localparam logic [2:0] S_WR_AW = 3'd3;
   localparam logic [2:0] S_WR_B  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]           state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 we_q, we_d;
   logic [ADDR_WDTH-1:0] addr_q, addr_d;
   logic [DATA_WDTH-1:0] wdata_q, wdata_d;
   logic                 last_grant_q, last_grant_d;
   logic                 aw_done_q, aw_done_d;
   logic                 w_done_q, w_done_d;
   logic [DATA_WDTH-1:0] xfer_data_q, xfer_data_d;
   logic [RESP_WDTH-1:0] xfer_resp_q, xfer_resp_d;

   logic                 grant_vld;
   logic                 grant;
   logic                 sel_we;
   logic [ADDR_WDTH-1:0] sel_addr;
   logic [DATA_WDTH-1:0] sel_wdata;
   logic                 aw_hs;
   logic                 w_hs;

   logic [1:0]           ack_w;
   logic [1:0]           done_w;
   logic [DATA_WDTH-1:0] rdata_w [2];
   logic [RESP_WDTH-1:0] resp_w  [2];

   // Round robin: on a tie, the requester that did not win last time goes first.
   always_comb begin
      grant_vld = (state_q == S_IDLE) && (m0_req || m1_req);
      if (m0_req && m1_req) begin
         grant = ~last_grant_q;
      end else begin
         grant = m1_req;
      end
      sel_we    = grant ? m1_we    : m0_we;
      sel_addr  = grant ? m1_addr  : m0_addr;
      sel_wdata = grant ? m1_wdata : m0_wdata;
   end

   // Channel outputs are decoded from registered state, so they drop the
   // moment rst is asserted.
   assign ar_valid = (state_q == S_RD_A);
   assign ar_addr  = addr_q;
   assign r_ready  = (state_q == S_RD_D);
   assign aw_valid = (state_q == S_WR_AW) && !aw_done_q;
   assign aw_addr  = addr_q;
   assign w_valid  = (state_q == S_WR_AW) && !w_done_q;
   assign w_data   = wdata_q;
   assign b_ready  = (state_q == S_WR_B);

   assign aw_hs = aw_valid && aw_ready;
   assign w_hs  = w_valid && w_ready;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      xfer_data_d  = xfer_data_q;
      xfer_resp_d  = xfer_resp_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               owner_d      = grant;
               last_grant_d = grant;
               we_d         = sel_we;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               state_d      = sel_we ? S_WR_AW : S_RD_A;
            end
         end
         S_RD_A: begin
            if (ar_ready) state_d = S_RD_D;
         end
         S_RD_D: begin
            if (r_valid) begin
               xfer_data_d = r_data;
               xfer_resp_d = r_resp;
               state_d     = S_DONE;
            end
         end
         S_WR_AW: begin
            // AW and W complete independently, in either order or together.
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WR_B;
            end
         end
         S_WR_B: begin
            if (b_valid) begin
               xfer_resp_d = b_resp;
               state_d     = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         last_grant_q <= 1'b1;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         xfer_data_q  <= '0;
         xfer_resp_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_grant_q <= last_grant_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         xfer_data_q  <= xfer_data_d;
         xfer_resp_q  <= xfer_resp_d;
      end
   end

   // Per-requester result registers and pulses. Results are published in the
   // cycle after DONE together with the done pulse; writes keep old rdata.
   for (genvar gi = 0; gi < 2; gi++) begin : gen_port
      localparam logic PORT = 1'(gi);
      logic                 ack_q, ack_d;
      logic                 done_q, done_d;
      logic [DATA_WDTH-1:0] rdata_q, rdata_d;
      logic [RESP_WDTH-1:0] resp_q, resp_d;

      always_comb begin
         ack_d   = grant_vld && (grant == PORT);
         done_d  = (state_q == S_DONE) && (owner_q == PORT);
         rdata_d = rdata_q;
         resp_d  = resp_q;
         if (done_d) begin
            resp_d = xfer_resp_q;
            if (!we_q) rdata_d = xfer_data_q;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
         end else begin
            ack_q   <= ack_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
         end
      end

      assign ack_w[gi]   = ack_q;
      assign done_w[gi]  = done_q;
      assign rdata_w[gi] = rdata_q;
      assign resp_w[gi]  = resp_q;
   end

   assign m0_ack   = ack_w[0];
   assign m1_ack   = ack_w[1];
   assign m0_done  = done_w[0];
   assign m1_done  = done_w[1];
   assign m0_rdata = rdata_w[0];
   assign m1_rdata = rdata_w[1];
   assign m0_resp  = resp_w[0];
   assign m1_resp  = resp_w[1];

endmodule
